// File: rtl/dlfloat_pkg.sv
// Shared DLFloat16 types and constants for the operand loader and pair FIFO.
package dlfloat_pkg;

  typedef logic [15:0] dlfloat16_t;

  localparam dlfloat16_t DLF_ZERO = 16'h0000;
  localparam dlfloat16_t DLF_NAN  = 16'hFFFF;

  typedef enum logic [1:0] {
    LO_A = 2'd0,
    HI_A = 2'd1,
    LO_B = 2'd2,
    HI_B = 2'd3
  } loader_state_t;

  // bit0: either operand is zero, bit1: either operand is the all-ones NaN code
  function automatic logic [1:0] dlf_pair_flags(input dlfloat16_t a, input dlfloat16_t b);
    return {(a == DLF_NAN) || (b == DLF_NAN), (a == DLF_ZERO) || (b == DLF_ZERO)};
  endfunction

endpackage

// File: rtl/dlfloat_pair_fifo.sv
// Circular FIFO holding assembled operand pairs; read data is forced to zero when empty.
module dlfloat_pair_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = empty ? '0 : mem[rd_ptr];

  // DEPTH is a power of two, so pointer overflow is the modulo wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      level <= level + 1'b1;
      else if (do_pop && !do_push) level <= level - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/dlfloat_operand_loader.sv
// Assembles a byte stream into DLFloat16 A/B pairs and queues them for the MAC.
// Optional class flags per pair are built when DLF_LOADER_SPECIAL_EN is defined.
//
// state | meaning
// LO_A  | waiting for A[7:0]
// HI_A  | waiting for A[15:8]
// LO_B  | waiting for B[7:0]
// HI_B  | waiting for B[15:8]; pushes the pair, stalls while FIFO full
module dlfloat_operand_loader
  import dlfloat_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic [7:0]               in_byte,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [15:0]              op_a,
  output logic [15:0]              op_b,
  output logic                     op_valid,
  input  logic                     op_ready,
  output logic [1:0]               op_special,
  output logic [$clog2(DEPTH):0]   fifo_level
);

`ifdef DLF_LOADER_SPECIAL_EN
  localparam int EW = 34;
`else
  localparam int EW = 32;
`endif

  loader_state_t state;
  dlfloat16_t    a_q;
  logic [7:0]    b_lo_q;
  dlfloat16_t    b_word;
  logic          accept;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic [EW-1:0] wr_data;
  logic [EW-1:0] rd_data;

  // full is a registered level, so a same-cycle pop cannot raise in_ready
  assign in_ready = !((state == HI_B) && full);
  assign accept   = in_valid && in_ready;
  assign push     = accept && (state == HI_B);
  assign op_valid = !empty;
  assign pop      = op_valid && op_ready;
  assign b_word   = {in_byte, b_lo_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= LO_A;
      a_q    <= '0;
      b_lo_q <= '0;
    end else if (clear) begin
      state <= LO_A;
    end else if (accept) begin
      case (state)
        LO_A: begin
          a_q[7:0] <= in_byte;
          state    <= HI_A;
        end
        HI_A: begin
          a_q[15:8] <= in_byte;
          state     <= LO_B;
        end
        LO_B: begin
          b_lo_q <= in_byte;
          state  <= HI_B;
        end
        default: state <= LO_A;
      endcase
    end
  end

`ifdef DLF_LOADER_SPECIAL_EN
  assign wr_data    = {dlf_pair_flags(a_q, b_word), b_word, a_q};
  assign op_special = rd_data[33:32];
`else
  assign wr_data    = {b_word, a_q};
  assign op_special = 2'b00;
`endif

  assign op_a = rd_data[15:0];
  assign op_b = rd_data[31:16];

  dlfloat_pair_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear),
    .push    (push),
    .wr_data (wr_data),
    .pop     (pop),
    .rd_data (rd_data),
    .empty   (empty),
    .full    (full),
    .level   (fifo_level)
  );

endmodule
